// File: rtl/id_pkg.sv
// Shared decode constants, ALU codes and the decoder result struct for the
// id_pipe decode stage.
package id_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 32;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;

  localparam logic [OP_W-1:0] FN_SLL = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA = 6'h03;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;

  localparam logic [IMM_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_SRL = 8'h02,
    ALU_SRA = 8'h03,
    ALU_AND = 8'h24,
    ALU_OR  = 8'h25,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27,
    ALU_SLL = 8'h7C
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'd0,
    SEL_LOGIC = 3'd1,
    SEL_SHIFT = 3'd2
  } alusel_e;

  // imm carries the value substituted for whichever read port is unused.
  typedef struct packed {
    aluop_e           aluop;
    alusel_e          alusel;
    logic             reg1_read;
    logic             reg2_read;
    logic [REG_W-1:0] raddr1;
    logic [REG_W-1:0] raddr2;
    logic [REG_W-1:0] wd;
    logic             wreg;
    logic [IMM_W-1:0] imm;
    logic             invalid;
  } dec_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder for the logic/shift MIPS subset.
module id_decode
  import id_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output dec_t              dec_o
);

  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  funct;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] sa;
  logic [15:0]      imm16;

  assign op    = inst_i[31:26];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  always_comb begin
    dec_o         = '0;
    dec_o.aluop   = ALU_NOP;
    dec_o.alusel  = SEL_NOP;
    dec_o.imm     = ZERO_WORD;
    dec_o.invalid = 1'b1;
    dec_o.raddr1  = inst_i[25:21];
    dec_o.raddr2  = rt;

    unique case (op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        dec_o.invalid   = 1'b0;
        dec_o.alusel    = SEL_LOGIC;
        dec_o.reg1_read = 1'b1;
        dec_o.wd        = rt;
        dec_o.wreg      = 1'b1;
        dec_o.imm       = IMM_W'({16'h0000, imm16});
        unique case (op)
          OP_ANDI: dec_o.aluop = ALU_AND;
          OP_XORI: dec_o.aluop = ALU_XOR;
          OP_LUI: begin
            dec_o.aluop = ALU_OR;
            dec_o.imm   = IMM_W'({imm16, 16'h0000});
          end
          default: dec_o.aluop = ALU_OR;
        endcase
      end
      OP_SPECIAL: begin
        unique case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            dec_o.invalid   = 1'b0;
            dec_o.alusel    = SEL_LOGIC;
            dec_o.reg1_read = 1'b1;
            dec_o.reg2_read = 1'b1;
            dec_o.wd        = rd;
            dec_o.wreg      = 1'b1;
            unique case (funct)
              FN_AND:  dec_o.aluop = ALU_AND;
              FN_OR:   dec_o.aluop = ALU_OR;
              FN_XOR:  dec_o.aluop = ALU_XOR;
              default: dec_o.aluop = ALU_NOR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_o.invalid   = 1'b0;
            dec_o.alusel    = SEL_SHIFT;
            dec_o.reg2_read = 1'b1;
            dec_o.wd        = rd;
            dec_o.wreg      = 1'b1;
            dec_o.imm       = IMM_W'(sa);
            unique case (funct)
              FN_SRL:  dec_o.aluop = ALU_SRL;
              FN_SRA:  dec_o.aluop = ALU_SRA;
              default: dec_o.aluop = ALU_SLL;
            endcase
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    // Writes to $0 are architecturally discarded.
    if (dec_o.wd == '0) dec_o.wreg = 1'b0;
  end

endmodule

// File: rtl/id_pipe.sv
// Decode stage with operand forwarding, load-use stall and the ID/EX
// pipeline register behind valid/ready handshakes.
module id_pipe
  import id_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned RAW      = 5,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_inst,
  input  logic                flush,
  output logic [RAW-1:0]      reg1_addr_o,
  output logic [RAW-1:0]      reg2_addr_o,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  input  logic [DW-1:0]       reg1_data_i,
  input  logic [DW-1:0]       reg2_data_i,
  input  logic                ex_valid,
  input  logic                ex_wreg,
  input  logic                ex_is_load,
  input  logic [RAW-1:0]      ex_wd,
  input  logic [DW-1:0]       ex_wdata,
  input  logic                mem_wreg,
  input  logic [RAW-1:0]      mem_wd,
  input  logic [DW-1:0]       mem_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [ALUOP_W-1:0]  out_aluop,
  output logic [ALUSEL_W-1:0] out_alusel,
  output logic [DW-1:0]       out_reg1,
  output logic [DW-1:0]       out_reg2,
  output logic [RAW-1:0]      out_wd,
  output logic                out_wreg,
  output logic                out_inst_invalid
);

  dec_t dec;

  id_decode u_dec (
    .inst_i (in_inst),
    .dec_o  (dec)
  );

  logic [RAW-1:0] addr1, addr2;
  logic [DW-1:0]  imm_ext, op1, op2;
  logic           ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic           hazard, accept;

  assign addr1       = RAW'(dec.raddr1);
  assign addr2       = RAW'(dec.raddr2);
  assign reg1_addr_o = addr1;
  assign reg2_addr_o = addr2;
  assign reg1_read_o = dec.reg1_read;
  assign reg2_read_o = dec.reg2_read;
  assign imm_ext     = DW'(dec.imm);

  assign ex_hit1  = ex_valid & ex_wreg & (ex_wd == addr1);
  assign ex_hit2  = ex_valid & ex_wreg & (ex_wd == addr2);
  assign mem_hit1 = mem_wreg & (mem_wd == addr1);
  assign mem_hit2 = mem_wreg & (mem_wd == addr2);

  function automatic logic [DW-1:0] resolve(input logic used, input logic zero_addr,
                                            input logic ex_hit, input logic mem_hit,
                                            input logic [DW-1:0] rf, input logic [DW-1:0] imm);
    if (!used)                               return imm;
    else if (zero_addr)                      return '0;
    else if (FWD_EN && ex_hit && !ex_is_load) return ex_wdata;
    else if (FWD_EN && mem_hit)               return mem_wdata;
    else                                     return rf;
  endfunction

  function automatic logic port_hazard(input logic used, input logic zero_addr,
                                       input logic ex_hit, input logic mem_hit);
    return used && !zero_addr &&
           ((ex_hit && ex_is_load) || (!FWD_EN && (ex_hit || mem_hit)));
  endfunction

  always_comb begin
    op1    = resolve(dec.reg1_read, addr1 == '0, ex_hit1, mem_hit1, reg1_data_i, imm_ext);
    op2    = resolve(dec.reg2_read, addr2 == '0, ex_hit2, mem_hit2, reg2_data_i, imm_ext);
    hazard = port_hazard(dec.reg1_read, addr1 == '0, ex_hit1, mem_hit1) |
             port_hazard(dec.reg2_read, addr2 == '0, ex_hit2, mem_hit2);
  end

  logic valid_q, valid_d;

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush beats accept; a drained output with nothing accepted becomes a bubble.
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  logic [31:0]         pc_q;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [ALUSEL_W-1:0] alusel_q;
  logic [DW-1:0]       reg1_q, reg2_q;
  logic [RAW-1:0]      wd_q;
  logic                wreg_q, invalid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      aluop_q   <= '0;
      alusel_q  <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q      <= in_pc;
        aluop_q   <= ALUOP_W'(dec.aluop);
        alusel_q  <= ALUSEL_W'(dec.alusel);
        reg1_q    <= op1;
        reg2_q    <= op2;
        wd_q      <= RAW'(dec.wd);
        wreg_q    <= dec.wreg;
        invalid_q <= dec.invalid;
      end
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = pc_q;
  assign out_aluop        = aluop_q;
  assign out_alusel       = alusel_q;
  assign out_reg1         = reg1_q;
  assign out_reg2         = reg2_q;
  assign out_wd           = wd_q;
  assign out_wreg         = wreg_q;
  assign out_inst_invalid = invalid_q;

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: expected ID/EX contents are queued on accept
// and compared when EX takes the instruction.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        ex_valid, ex_wreg, ex_is_load, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;
  logic [31:0] reg1_data, reg2_data;
  logic [31:0] rf [32];

  logic        in_ready, reg1_read, reg2_read, out_valid, out_wreg, out_inv;
  logic [4:0]  reg1_addr, reg2_addr, out_wd;
  logic [31:0] out_pc, out_reg1, out_reg2;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel;

  logic        n_in_ready, n_r1rd, n_r2rd, n_out_valid, n_out_wreg, n_out_inv;
  logic [4:0]  n_r1a, n_r2a, n_out_wd;
  logic [31:0] n_out_pc, n_out_reg1, n_out_reg2;
  logic [7:0]  n_out_aluop;
  logic [2:0]  n_out_alusel;

  always #5 clk = ~clk;

  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  id_pipe #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load),
    .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wd(out_wd),
    .out_wreg(out_wreg), .out_inst_invalid(out_inv)
  );

  id_pipe #(.FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .reg1_addr_o(n_r1a), .reg2_addr_o(n_r2a),
    .reg1_read_o(n_r1rd), .reg2_read_o(n_r2rd),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load),
    .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_aluop(n_out_aluop), .out_alusel(n_out_alusel),
    .out_reg1(n_out_reg1), .out_reg2(n_out_reg2), .out_wd(n_out_wd),
    .out_wreg(n_out_wreg), .out_inst_invalid(n_out_inv)
  );

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic        inv;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [7:0] aluop,
                              input logic [2:0] alusel, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [4:0] wd,
                              input logic wreg, input logic inv, input logic full);
    exp_t e;
    e.pc = pc; e.aluop = aluop; e.alusel = alusel; e.r1 = r1; e.r2 = r2;
    e.wd = wd; e.wreg = wreg; e.inv = inv; e.full = full;
    return e;
  endfunction

  // Pop on every transfer to EX; a flushed output is discarded unchecked.
  always @(negedge clk) begin
    if (rst && out_valid && (flush || out_ready)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!flush) begin
          chk("pc", out_pc, e.pc);
          chk("aluop", out_aluop, e.aluop);
          chk("alusel", out_alusel, e.alusel);
          chk("wreg", out_wreg, e.wreg);
          chk("invalid", out_inv, e.inv);
          if (e.full) begin
            chk("reg1", out_reg1, e.r1);
            chk("reg2", out_reg2, e.r2);
            chk("wd", out_wd, e.wd);
          end
        end
      end
    end
  end

  // Present one instruction from posedge+1 and hold it until accepted.
  task automatic send(input logic [31:0] inst, input exp_t e, output int waited);
    bit ok = 0;
    in_pc = e.pc; in_inst = inst; in_valid = 1'b1; waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] b2b_inst [6];
  exp_t        b2b_exp  [6];

  initial begin
    int w;
    int total;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0;
    ex_valid = 0; ex_wreg = 0; ex_is_load = 0; ex_wd = '0; ex_wdata = '0;
    mem_wreg = 0; mem_wd = '0; mem_wdata = '0;
    rf[0] = 32'hDEAD_0000;
    for (int i = 1; i < 32; i++) rf[i] = 32'h1000 + i;

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_aluop", out_aluop, 0);
    chk("rst_alusel", out_alusel, 0);
    chk("rst_reg1", out_reg1, 0);
    chk("rst_wreg", out_wreg, 0);
    chk("rst_inv", out_inv, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // ORI $1,$0,0x1100 with a nonzero junk value behind $0
    send(32'h3401_1100, mk(32'h100, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1, 0, 1), w);
    chk("lat_valid", out_valid, 1);
    chk("lat_wd", out_wd, 1);

    // Writers targeting $0 are neither forwarded nor cause stalls
    ex_valid = 1; ex_wreg = 1; ex_wd = 5'd0; ex_wdata = 32'h5555;
    mem_wreg = 1; mem_wd = 5'd0; mem_wdata = 32'h6666;
    send(32'h3401_1100, mk(32'h104, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1, 0, 1), w);
    chk("zero_nostall", w, 0);

    // EX beats MEM
    ex_wd = 5'd1; ex_wdata = 32'h1100; mem_wd = 5'd1; mem_wdata = 32'hBEEF;
    send(32'h3422_0020, mk(32'h108, 8'h25, 3'd1, 32'h1100, 32'h20, 5'd2, 1, 0, 1), w);
    @(negedge clk);
    chk("nofwd_ex_stall", n_in_ready, 0);
    @(posedge clk); #1;
    ex_valid = 0;
    @(negedge clk);
    chk("nofwd_mem_stall", n_in_ready, 0);
    @(posedge clk); #1;
    send(32'h3422_0020, mk(32'h10C, 8'h25, 3'd1, 32'hBEEF, 32'h20, 5'd2, 1, 0, 1), w);
    mem_wreg = 0;
    @(negedge clk);
    chk("nofwd_clear", n_in_ready, 1);
    @(posedge clk); #1;

    // Load-use: OR $4,$3,$5 behind a load to $3
    ex_valid = 1; ex_wreg = 1; ex_is_load = 1; ex_wd = 5'd3; ex_wdata = 32'h7777;
    in_pc = 32'h110; in_inst = 32'h0065_2025; in_valid = 1'b1;
    @(negedge clk);
    chk("lu_ready", in_ready, 0);
    chk("or_r1read", reg1_read, 1);
    chk("or_r2read", reg2_read, 1);
    chk("or_r1addr", reg1_addr, 3);
    chk("or_r2addr", reg2_addr, 5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_bubble", out_valid, 0);
    chk("lu_ready2", in_ready, 0);
    @(posedge clk); #1;
    ex_valid = 0; ex_is_load = 0; mem_wreg = 1; mem_wd = 5'd3; mem_wdata = 32'h7777;
    send(32'h0065_2025, mk(32'h110, 8'h25, 3'd1, 32'h7777, 32'h1005, 5'd4, 1, 0, 1), w);
    chk("lu_release", w, 0);
    mem_wreg = 0;

    // Backpressure: XORI held for 3 cycles while ANDI waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h3845_00FF, mk(32'h114, 8'h26, 3'd1, 32'h1002, 32'hFF, 5'd5, 1, 0, 1), w);
    in_pc = 32'h118; in_inst = 32'h3026_0F0F; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("st_ready", in_ready, 0);
      chk("st_valid", out_valid, 1);
      chk("st_reg1", out_reg1, 32'h1002);
      chk("st_aluop", out_aluop, 8'h26);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h3026_0F0F, mk(32'h118, 8'h24, 3'd1, 32'h1001, 32'hF0F, 5'd6, 1, 0, 1), w);
    chk("st_release", w, 0);
    chk("st_loaded_pc", out_pc, 32'h118);

    // Flush with a valid output and a pending SRA $6,$7,4
    out_ready = 1'b0; flush = 1'b1;
    in_pc = 32'h11C; in_inst = 32'h0007_3103; in_valid = 1'b1;
    @(negedge clk);
    chk("fl_ready", in_ready, 0);
    chk("sra_r1read", reg1_read, 0);
    chk("sra_r2read", reg2_read, 1);
    chk("sra_r2addr", reg2_addr, 7);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_pc_kept", out_pc, 32'h118);
    out_ready = 1'b1;
    send(32'h0007_3103, mk(32'h11C, 8'h03, 3'd2, 32'h4, 32'h1007, 5'd6, 1, 0, 1), w);

    // Back-to-back stream
    b2b_inst[0] = 32'hFC00_0000; b2b_exp[0] = mk(32'h120, 8'h00, 3'd0, 0, 0, 0, 0, 1, 0);
    b2b_inst[1] = 32'h0000_0000; b2b_exp[1] = mk(32'h124, 8'h7C, 3'd2, 0, 0, 0, 0, 0, 1);
    b2b_inst[2] = 32'h012A_4027; b2b_exp[2] = mk(32'h128, 8'h27, 3'd1, 32'h1009, 32'h100A, 5'd8, 1, 0, 1);
    b2b_inst[3] = 32'h3C0B_1234; b2b_exp[3] = mk(32'h12C, 8'h25, 3'd1, 0, 32'h1234_0000, 5'd11, 1, 0, 1);
    b2b_inst[4] = 32'h000D_67C2; b2b_exp[4] = mk(32'h130, 8'h02, 3'd2, 32'h1F, 32'h100D, 5'd12, 1, 0, 1);
    b2b_inst[5] = 32'h3420_0005; b2b_exp[5] = mk(32'h134, 8'h25, 3'd1, 32'h1001, 32'h5, 5'd0, 0, 0, 1);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      send(b2b_inst[i], b2b_exp[i], w);
      total += w;
    end
    chk("b2b_stalls", total, 0);

    // Asynchronous reset while an instruction is held
    send(32'h3401_1100, mk(32'h140, 8'h25, 3'd1, 0, 32'h1100, 5'd1, 1, 0, 1), w);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_reg2", out_reg2, 0);
    chk("arst_aluop", out_aluop, 0);
    chk("arst_wd", out_wd, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
